// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Widest PC the prefetch queue can carry; fetch_ctrl's ADDR_WIDTH must not exceed it.
    localparam int FETCH_ADDR_WIDTH = 32;

    // Every instruction word is four bytes, so the PC advances by this amount.
    localparam int INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [31:0]                 instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched instructions between memory and decode.
// Pointers carry one extra wrap bit so full and empty are distinguished without a flag.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

    logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
    fetch_entry_t   mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;
    logic           empty;
    logic           full;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Pointer update: a flush wins over everything, otherwise guarded push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

    // Present zeros while empty so decode never sees a stale entry.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem_q[rd_ptr_q[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues word requests via req/gnt, buffers the
// one-cycle-latency responses in a prefetch queue and restarts on redirect.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic [31:0]           imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        outstanding;
    logic                  grant;
    logic                  push;
    logic                  pop;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;
    logic [1:0]            unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // Credit check uses only registered state, so there is no path from decode ready to req.
    always_comb begin
        outstanding = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        imem_req_o  = !rst && !redirect_i && (outstanding < DEPTH_C);
        grant       = imem_req_o && imem_gnt_i;
        push        = inflight_q && !redirect_i;
        pop         = instr_valid_o && instr_ready_i;
        push_entry.pc    = FETCH_ADDR_WIDTH'(resp_pc_q);
        push_entry.instr = imem_rdata_i;
    end

    // Next fetch address, response tag and in-flight flag; redirect outranks a grant.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = 1'b0;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
            resp_pc_d  = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    // Fetch state registers; reset overrides a simultaneous redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = head.instr;
    assign pc_o          = head.pc[ADDR_WIDTH-1:0];

    // Credits guarantee every response finds a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == DEPTH_C[CNT_W-1:0])));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (outstanding <= DEPTH_C));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a word-indexed memory model (word[i] = i).
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        gnt;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        chk_head;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [10];

    fetch_ctrl #(
        .DEPTH     (4),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .instr_ready_i(instr_ready_i)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single-cycle memory: the granted word index appears the cycle after the grant.
    always @(posedge clk) begin
        if (imem_req_o && imem_gnt_i) begin
            imem_rdata_i <= imem_addr_o >> 2;
        end else begin
            imem_rdata_i <= 32'hDEAD_BEEF;
        end
    end

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic g,
                                input logic rd, input logic er, input logic [31:0] ea,
                                input logic ch, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.redirect  = r;
        v.rpc       = rpc;
        v.gnt       = g;
        v.ready     = rd;
        v.exp_req   = er;
        v.exp_addr  = ea;
        v.chk_head  = ch;
        v.exp_valid = ev;
        v.exp_pc    = ev ? ep : 32'h0;
        v.exp_instr = ev ? (ep >> 2) : 32'h0;
        return v;
    endfunction

    // Drive one cycle's inputs on the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic rs, input logic r, input logic [31:0] rpc,
                                 input logic g, input logic rd);
        @(negedge clk);
        rst           = rs;
        redirect_i    = r;
        redirect_pc_i = rpc;
        imem_gnt_i    = g;
        instr_ready_i = rd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic v, input logic [31:0] pc);
        checkOutput({tag, "_valid"}, {31'b0, instr_valid_o}, {31'b0, v});
        checkOutput({tag, "_pc"},    pc_o,    v ? pc : 32'h0);
        checkOutput({tag, "_instr"}, instr_o, v ? (pc >> 2) : 32'h0);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("rst_req", {31'b0, imem_req_o}, 32'h0);
        checkHead("rst", 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] gaddr [$];
        logic [31:0] gaddr2 [$];

        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; instr_ready_i = 1'b0;

        // Streaming from reset, then redirect to 0x103 in cycle 5
        vecs[0] = mk(0, 0,      1, 1, 1, 32'h000, 1, 0, 0);
        vecs[1] = mk(0, 0,      1, 1, 1, 32'h004, 1, 0, 0);
        vecs[2] = mk(0, 0,      1, 1, 1, 32'h008, 1, 1, 32'h000);
        vecs[3] = mk(0, 0,      1, 1, 1, 32'h00C, 1, 1, 32'h004);
        vecs[4] = mk(0, 0,      1, 1, 1, 32'h010, 1, 1, 32'h008);
        vecs[5] = mk(1, 32'h103, 1, 1, 0, 32'h0,  0, 0, 0);
        vecs[6] = mk(0, 0,      1, 1, 1, 32'h100, 1, 0, 0);
        vecs[7] = mk(0, 0,      1, 1, 1, 32'h104, 1, 0, 0);
        vecs[8] = mk(0, 0,      1, 1, 1, 32'h108, 1, 1, 32'h100);
        vecs[9] = mk(0, 0,      1, 1, 1, 32'h10C, 1, 1, 32'h104);

        $display("[TB] streaming and redirect table");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, vecs[i].redirect, vecs[i].rpc, vecs[i].gnt, vecs[i].ready);
            checkOutput($sformatf("tbl%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) checkOutput($sformatf("tbl%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
            if (vecs[i].chk_head) checkHead($sformatf("tbl%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        $display("[TB] credit limit with decode stalled");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (imem_req_o && imem_gnt_i) gaddr.push_back(imem_addr_o);
        end
        checkOutput("full_grants", gaddr.size(), 4);
        for (int i = 0; i < gaddr.size() && i < 4; i++) checkOutput($sformatf("full_addr%0d", i), gaddr[i], 32'(4 * i));
        checkOutput("full_req_low", {31'b0, imem_req_o}, 32'h0);
        checkHead("full_head", 1'b1, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("pop_head", 1'b1, 32'h0);
        if (imem_req_o && imem_gnt_i) gaddr2.push_back(imem_addr_o);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (imem_req_o && imem_gnt_i) gaddr2.push_back(imem_addr_o);
        end
        checkOutput("refill_grants", gaddr2.size(), 1);
        if (gaddr2.size() > 0) checkOutput("refill_addr", gaddr2[0], 32'h10);
        checkHead("after_pop", 1'b1, 32'h4);

        $display("[TB] grant withheld");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput($sformatf("hold%0d_req", i), {31'b0, imem_req_o}, 32'h1);
            checkOutput($sformatf("hold%0d_addr", i), imem_addr_o, 32'h10);
        end
        checkHead("drained", 1'b0, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("resume_addr0", imem_addr_o, 32'h10);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("resume_addr1", imem_addr_o, 32'h14);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("resume_head", 1'b1, 32'h10);

        $display("[TB] redirect with pop on full queue");
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
        checkHead("pre_flush", 1'b1, 32'h0);
        applyStimulus(0, 1, 32'h40, 1, 1);
        checkOutput("flush_req", {31'b0, imem_req_o}, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("flush_n1", 1'b0, 32'h0);
        checkOutput("flush_n1_addr", imem_addr_o, 32'h40);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("flush_n2", 1'b0, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("flush_n3", 1'b1, 32'h40);

        $display("[TB] reset with simultaneous redirect");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(1, 1, 32'h200, 1, 1);
        checkOutput("rr_req", {31'b0, imem_req_o}, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("rr_n1", 1'b0, 32'h0);
        checkOutput("rr_n1_req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("rr_n1_addr", imem_addr_o, 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("rr_n2_addr", imem_addr_o, 32'h4);
        applyStimulus(0, 0, 0, 1, 1);
        checkHead("rr_n3", 1'b1, 32'h0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
